arb_mux8_32: RTL
================

# arb_mux8_32

Four-lane byte-stream scheduler that shares the single byte input of the 8-to-32 word multiplexer between four producers. Each grant covers exactly one 32-bit word (four consecutive bytes) so a word is never interleaved across lanes. Grants start only on a 4-cycle phase boundary, so every word reaches the multiplexer aligned to the slow clock. Sits directly upstream of the multiplexer's `data_in`/`valid_in` and runs in the `clk_4f` domain.

## Interface
- No parameters: 4 lanes, 8-bit bytes, 4 bytes per word, all fixed.

- `clk_4f`  in  1  byte-rate clock, the block's only clock; all state on rising edge.
- `reset_L`  in  1  asynchronous active-low reset.
- `req`  in  4  `req[i]`=1: lane i holds at least one complete 4-byte word at its head.
- `data_in0`..`data_in3`  in  8 each  head byte of lane i.
- `pop`  out  4  one-hot combinational; `pop[i]`=1: lane i's head byte is consumed this cycle.
- `data_out`  out  8  registered byte to the multiplexer's `data_in`.
- `valid_out`  out  1  registered; `data_out` carries a granted byte.
- `gnt_id`  out  2  registered; lane that owns the byte on `data_out`.
- `sof`  out  1  registered; first byte of a word is on `data_out`.

## Operation
- `phase`: free-running 2-bit counter, 0→1→2→3→0. Reset value 0.
- `ptr`: 2-bit round-robin pointer. Reset value 0. It is the highest-priority lane at the next decision.
- `state`: IDLE or BURST. Reset value IDLE. `gsel` holds the current grant.
- Decision point: any cycle with `phase`==3.
  - At a decision point, if `req`≠0, pick the first lane with `req` set, searching `ptr`, `ptr`+1, … mod 4.
  - Then `gsel`←that lane, `ptr`←lane+1 mod 4, `state`←BURST.
  - At a decision point with `req`==0: `state`←IDLE.
- IDLE with `phase`≠3: hold.
- BURST, phases 0..3: `pop[gsel]`=1 and all other `pop` bits are 0.
  - On each edge: `data_out`←`data_in[gsel]`, `valid_out`←1, `gnt_id`←`gsel`, `sof`←(`phase`==0).
  - The phase-3 cycle of a burst is also a decision point. A following grant therefore starts with no bubble, and the same lane may win again.
- When not in BURST: `pop`=0. Next edge: `valid_out`←0, `sof`←0, `data_out` and `gnt_id` hold.
- `req` is sampled only at decision points. Changes to `req` during a burst are ignored.
- Lane contract: a lane that raises `req` supplies 4 bytes on 4 consecutive `pop` cycles. The arbiter does not check this.
- Reset values: `pop`=0, `data_out`=8'h00, `valid_out`=0, `gnt_id`=0, `sof`=0, `phase`=0, `ptr`=0, `state`=IDLE.

## Timing
- A byte popped in cycle k appears on `data_out` after the edge ending cycle k (1-cycle latency).
- Word bytes appear on `data_out` while `phase` is 1, 2, 3, 0. `sof` is high in the `phase`==1 cycle.
- Back-to-back words give a continuous `valid_out`=1 stream with `sof` every 4th cycle.
- Worst-case wait from `req` rising to first `pop`: 4 cycles with no contention; 4 + 4·3 cycles behind three other lanes.
- Reset asserted mid-burst:
  - all registers clear immediately and the partial word is dropped;
  - lane queues are not rewound;
  - the multiplexer shares `reset_L`, so its word assembly restarts too.
- After `reset_L` deasserts, the first `pop` occurs no earlier than the 4th edge (first `phase`==3 decision).

## Configuration
- `ARB_FIXED_PRIO_EN` defined:
  - fixed priority, lane 0 highest, lane 3 lowest;
  - `ptr` is not implemented and the search always starts at lane 0.
- Not defined: round-robin as described in Operation.
- All other behaviour, latency and outputs are identical in both builds.

## Test plan
- Reset, then `req`=4'b0000 for 16 cycles → `pop`=0, `valid_out`=0, `sof`=0, `data_out`=8'h00 throughout.
- `req`=4'b0010 held from cycle 0, lane 1 bytes A0,A1,A2,A3 → `pop`=4'b0010 on `phase` 0..3 of the first burst; `data_out` A0..A3 with `sof`=1 on A0 and `gnt_id`=1; repeats with no gap while `req` stays high.
- `req`=4'b1111 held (round-robin build) → grants lanes 0,1,2,3,0; `sof` every 4 cycles; `valid_out` continuously 1.
- `req`=4'b1111 held with `ARB_FIXED_PRIO_EN` → every word is from lane 0, `gnt_id`=0 throughout.
- `req[2]` rises at `phase`==1 while idle → no `pop` until the `phase`==3 decision, then `pop`=4'b0100 for phases 0..3.
- `reset_L` pulsed low at the 2nd byte of a lane-3 burst → same cycle: `pop`=0, `valid_out`=0, `gnt_id`=0; after release the next grant starts at lane 0 (`ptr`=0).

Source files
------------

// File: rtl/arb_mux8_32_if.sv
// Byte-stream bundle between four lane producers, the arbiter and the 8-to-32 multiplexer.
// master: arbiter side (consumes req/head bytes, drives pop and the registered byte stream).
// slave: producer/multiplexer side.
interface arb_mux8_32_if;
  logic [3:0] req;
  logic [7:0] data_in0;
  logic [7:0] data_in1;
  logic [7:0] data_in2;
  logic [7:0] data_in3;
  logic [3:0] pop;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] gnt_id;
  logic       sof;

  modport master (
    input  req, data_in0, data_in1, data_in2, data_in3,
    output pop, data_out, valid_out, gnt_id, sof
  );

  modport slave (
    output req, data_in0, data_in1, data_in2, data_in3,
    input  pop, data_out, valid_out, gnt_id, sof
  );
endinterface

// File: rtl/arb_mux8_32.sv
// Four-lane word-granular scheduler feeding the 8-to-32 mux; grants start on phase-3 decisions.
// Latency: popped byte appears on data_out one edge later; req-to-first-pop at most 4 cycles uncontended.
// Backpressure: none downstream; lanes are throttled only through the one-hot combinational pop.
// Optional build macro ARB_FIXED_PRIO_EN: fixed priority (lane 0 highest) instead of round-robin.
module arb_mux8_32 (
  input  logic          clk_4f,
  input  logic          reset_L,
  arb_mux8_32_if.master bus
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t     state;
  logic [1:0] phase;
  logic [1:0] gsel;
  logic [1:0] start;
  logic [1:0] win;
  logic       win_vld;
  logic       decide;
  logic [7:0] sel_byte;

  logic [7:0] data_out_q;
  logic       valid_out_q;
  logic [1:0] gnt_id_q;
  logic       sof_q;

  assign decide = (phase == 2'd3);

`ifdef ARB_FIXED_PRIO_EN
  // Search always begins at lane 0, so no rotating pointer exists.
  assign start = 2'd0;
`else
  logic [1:0] ptr;

  assign start = ptr;

  // Rotate priority past the lane that just won a word.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= 2'd0;
    end else if (decide && win_vld) begin
      ptr <= win + 2'd1;
    end
  end
`endif

  // First requesting lane at or after start; scanning backwards lets the nearest lane win.
  always_comb begin
    win     = 2'd0;
    win_vld = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (bus.req[start + 2'(i)]) begin
        win     = start + 2'(i);
        win_vld = 1'b1;
      end
    end
  end

  // Head byte of the currently granted lane.
  always_comb begin
    case (gsel)
      2'd0:    sel_byte = bus.data_in0;
      2'd1:    sel_byte = bus.data_in1;
      2'd2:    sel_byte = bus.data_in2;
      default: sel_byte = bus.data_in3;
    endcase
  end

  // Phase counter, grant FSM and registered byte stream; a phase-3 burst cycle also decides the next word.
  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      phase       <= 2'd0;
      state       <= IDLE;
      gsel        <= 2'd0;
      data_out_q  <= 8'h00;
      valid_out_q <= 1'b0;
      gnt_id_q    <= 2'd0;
      sof_q       <= 1'b0;
    end else begin
      phase <= phase + 2'd1;
      if (state == BURST) begin
        data_out_q  <= sel_byte;
        valid_out_q <= 1'b1;
        gnt_id_q    <= gsel;
        sof_q       <= (phase == 2'd0);
      end else begin
        valid_out_q <= 1'b0;
        sof_q       <= 1'b0;
      end
      if (decide) begin
        if (win_vld) begin
          gsel  <= win;
          state <= BURST;
        end else begin
          state <= IDLE;
        end
      end
    end
  end

  assign bus.pop       = (state == BURST) ? (4'b0001 << gsel) : 4'b0000;
  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.sof       = sof_q;

endmodule
